melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Plays a fixed note sequence on the piezo buzzer pin. Each ROM entry holds a tone half-period count and a duration in milliseconds. The block steps through the ROM, drives a programmable square-wave tone generator for each note, and inserts a fixed silent gap between notes. It sits between the board buttons/control logic and the buzzer output, and replaces the fixed-frequency dividers as the single owner of the buzzer.

## Interface
Parameters:
- TICK_DIV, 50000: clk_50MHz cycles per millisecond tick.
- GAP_MS, 20: silence between notes, in ms; 0 means no gap.
- SONG_LEN, 16: ROM depth; index width is clog2(SONG_LEN).

Ports:
- clk_50MHz  in  1  system clock, 50 MHz.
- reset_button  in  1  asynchronous, active-high reset.
- start  in  1  level or pulse, sampled in IDLE only.
- stop  in  1  abort request, sampled every cycle.
- buzzer_out  out  1  square-wave tone, low when silent.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at natural end of song.
- note_idx  out  clog2(SONG_LEN)  index of current ROM entry.

## Operation
- ROM entry: {half_period[17:0], dur_ms[11:0]}.
  - half_period = 0 marks a rest (buzzer stays low for dur_ms).
  - dur_ms = 0 marks end of song.
- States: IDLE, LOAD, PLAY, GAP, END.
- IDLE: on start=1 and stop=0, clear note_idx to 0 and go to LOAD.
- LOAD: one cycle; read ROM[note_idx].
  - dur_ms = 0 → END.
  - otherwise → PLAY, with tone counter = 0, buzzer_out = 0, ms counters cleared.
- PLAY: tone counter increments; when it equals half_period, it clears and buzzer_out toggles. Tone period is 2·(half_period+1) cycles. After dur_ms ticks, go to GAP (or straight to the advance step when GAP_MS = 0).
- GAP: buzzer_out = 0 for GAP_MS ticks, then advance.
- Advance: note_idx+1. If the result equals SONG_LEN → END, else → LOAD.
- END: pulse done for one cycle → IDLE; note_idx holds its last value.
- stop=1 in any non-IDLE state: next state is IDLE, buzzer_out = 0, no done pulse. stop has priority over start and over every other transition.
- start while busy is ignored.
- Reset values: state IDLE, buzzer_out 0, busy 0, done 0, note_idx 0, all counters 0. Reset mid-note silences the buzzer immediately, since the reset is asynchronous.

## Timing
- start in IDLE at cycle t: LOAD at t+1, PLAY at t+2, first buzzer_out rise at t+2+half_period+1.
- PLAY lasts exactly dur_ms·TICK_DIV cycles. GAP lasts exactly GAP_MS·TICK_DIV cycles.
- Tone phase restarts at every note; there is no phase carry between notes.
- done is asserted in the cycle the FSM is in END. busy falls the following cycle.
- Arithmetic: the ms counter is 12 bits and the tick counter is clog2(TICK_DIV) bits; neither wraps, because they compare with == and clear. The tone counter is 18 bits.

## Configuration
- MELODY_LOOP_EN defined:
  - An end marker, or note_idx reaching SONG_LEN, returns to LOAD with note_idx = 0.
  - done pulses once per pass, coincident with the wrap.
  - busy stays high until stop.
- Undefined: the block plays once, pulses done, then returns to IDLE.

## Structure
- Package melody_pkg holds:
  - state enum;
  - entry typedef (half_period, dur_ms);
  - note constants: C5=47750, D5=42564, E5=37920, F5=35792, G5=31887, A5=28408, B5=25309, C6=23888, REST=0;
  - song_rom(idx) function. Default content is the C5..C6 scale at 250 ms per note, then an end marker at index 8.
- Sub-module tone_gen (clk, reset, enable, half_period, tone_out): holds the programmable tone counter. It clears when enable=0.

## Test plan
Directed scenarios, each stimulus → required response:
- Scale playback, TICK_DIV=50, GAP_MS=2. Pulse start → 8 notes. Note 0 period = 95502 cycles, PLAY = 12500 cycles per note; done pulses once after index 8; busy then drops.
- Tone edges. half_period=4, dur_ms=3, TICK_DIV=10 → buzzer toggles every 5 cycles, 3 full periods, then 20 low cycles.
- Stop mid-note at note_idx=3 → buzzer_out = 0 and busy = 0 next cycle; no done; a new start replays from index 0.
- start and stop in the same IDLE cycle → remains IDLE. start while busy → note_idx sequence unaffected.
- Reset asserted during PLAY → all outputs 0 asynchronously; after release the block sits in IDLE with note_idx=0.
- MELODY_LOOP_EN defined → after index 7, note_idx returns to 0 with a done pulse; playback continues until stop.

Source files
------------

// File: rtl/melody_pkg.sv
// melody_pkg: shared types, note constants and the song ROM contents for
// melody_sequencer. Optional build macro used by the top: MELODY_LOOP_EN.
package melody_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP,
    END
  } state_t;

  // One ROM word: tone half-period in clock cycles, note length in ms.
  typedef struct packed {
    logic [17:0] half_period;
    logic [11:0] dur_ms;
  } entry_t;

  localparam logic [17:0] C5   = 18'd47750;
  localparam logic [17:0] D5   = 18'd42564;
  localparam logic [17:0] E5   = 18'd37920;
  localparam logic [17:0] F5   = 18'd35792;
  localparam logic [17:0] G5   = 18'd31887;
  localparam logic [17:0] A5   = 18'd28408;
  localparam logic [17:0] B5   = 18'd25309;
  localparam logic [17:0] C6   = 18'd23888;
  localparam logic [17:0] REST = 18'd0;

  localparam logic [11:0] NOTE_MS = 12'd250;

  // C5..C6 scale, then end markers (dur_ms = 0) for every remaining slot.
  function automatic entry_t song_rom(input int unsigned idx);
    entry_t e;
    case (idx)
      0:       e = '{half_period: C5,   dur_ms: NOTE_MS};
      1:       e = '{half_period: D5,   dur_ms: NOTE_MS};
      2:       e = '{half_period: E5,   dur_ms: NOTE_MS};
      3:       e = '{half_period: F5,   dur_ms: NOTE_MS};
      4:       e = '{half_period: G5,   dur_ms: NOTE_MS};
      5:       e = '{half_period: A5,   dur_ms: NOTE_MS};
      6:       e = '{half_period: B5,   dur_ms: NOTE_MS};
      7:       e = '{half_period: C6,   dur_ms: NOTE_MS};
      default: e = '{half_period: REST, dur_ms: 12'd0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// tone_gen: programmable square-wave generator. The output toggles every
// half_period+1 enabled cycles; dropping enable clears both the counter and
// the output so every note starts from the same phase.
module tone_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [17:0] half_period,
  output logic        tone_out
);

  logic [17:0] count_reg;
  logic        tone_reg;

  // Half-period counter with output toggle on terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      tone_reg  <= 1'b0;
    end else if (!enable) begin
      count_reg <= '0;
      tone_reg  <= 1'b0;
    end else if (count_reg == half_period) begin
      count_reg <= '0;
      tone_reg  <= ~tone_reg;
    end else begin
      count_reg <= count_reg + 18'd1;
    end
  end

  assign tone_out = tone_reg;

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps through the song ROM, plays each note on the
// buzzer through tone_gen and inserts a silent gap between notes.
// Build macro MELODY_LOOP_EN: wrap to index 0 at end of song instead of
// stopping (done pulses once per pass, busy stays high until stop).
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int GAP_MS   = 20,
  parameter int SONG_LEN = 16
) (
  input  logic                        clk_50MHz,
  input  logic                        reset_button,
  input  logic                        start,
  input  logic                        stop,
  output logic                        buzzer_out,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(SONG_LEN)-1:0] note_idx
);

  localparam int IDX_W  = $clog2(SONG_LEN);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [11:0]       GAP_LAST  = 12'(GAP_MS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SONG_LEN - 1);

  state_t            state_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [IDX_W-1:0]  note_idx_reg;
  logic [TICK_W-1:0] tick_reg;
  logic [11:0]       ms_reg;
  entry_t            cur_reg;

  entry_t rom_entry;
  logic   tick_last;
  logic   play_last;
  logic   gap_last;
  logic   advance;
  logic   song_end;
  logic   tone_enable;

  // Phase-end detection and next-note decisions shared by the FSM.
  always_comb begin
    rom_entry   = song_rom(32'(note_idx_reg));
    tick_last   = (tick_reg == TICK_LAST);
    play_last   = (state_reg == PLAY) && tick_last && (ms_reg == cur_reg.dur_ms - 12'd1);
    gap_last    = (state_reg == GAP) && tick_last && (ms_reg == GAP_LAST);
    advance     = (play_last && (GAP_MS == 0)) || gap_last;
    song_end    = ((state_reg == LOAD) && (rom_entry.dur_ms == 12'd0)) ||
                  (advance && (note_idx_reg == IDX_LAST));
    // Stop the tone on the same edge that leaves PLAY so the buzzer is
    // already low in the first cycle of the gap or of IDLE; rests never sound.
    tone_enable = (state_reg == PLAY) && !stop && !play_last &&
                  (cur_reg.half_period != 18'd0);
  end

  // Sequencer FSM with registered busy/done/note_idx outputs.
  always_ff @(posedge clk_50MHz or posedge reset_button) begin
    if (reset_button) begin
      state_reg    <= IDLE;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      note_idx_reg <= '0;
      tick_reg     <= '0;
      ms_reg       <= '0;
      cur_reg      <= '0;
    end else begin
      done_reg <= 1'b0;
      if (stop && (state_reg != IDLE)) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
        tick_reg  <= '0;
        ms_reg    <= '0;
      end else if (song_end) begin
        done_reg <= 1'b1;
        tick_reg <= '0;
        ms_reg   <= '0;
`ifdef MELODY_LOOP_EN
        state_reg    <= LOAD;
        note_idx_reg <= '0;
`else
        state_reg <= END;
`endif
      end else if (advance) begin
        state_reg    <= LOAD;
        note_idx_reg <= note_idx_reg + 1'b1;
        tick_reg     <= '0;
        ms_reg       <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start && !stop) begin
              state_reg    <= LOAD;
              busy_reg     <= 1'b1;
              note_idx_reg <= '0;
            end
          end
          LOAD: begin
            cur_reg   <= rom_entry;
            tick_reg  <= '0;
            ms_reg    <= '0;
            state_reg <= PLAY;
          end
          PLAY, GAP: begin
            if (play_last) begin
              state_reg <= GAP;
              tick_reg  <= '0;
              ms_reg    <= '0;
            end else if (tick_last) begin
              tick_reg <= '0;
              ms_reg   <= ms_reg + 12'd1;
            end else begin
              tick_reg <= tick_reg + 1'b1;
            end
          end
          END: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  tone_gen u_tone_gen (
    .clk         (clk_50MHz),
    .reset       (reset_button),
    .enable      (tone_enable),
    .half_period (cur_reg.half_period),
    .tone_out    (buzzer_out)
  );

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign note_idx = note_idx_reg;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: randomized start/stop stimulus against a timeline
// model of the song, plus a direct check of the tone generator.
module tb_melody_sequencer;

  localparam int TD = 10;
  localparam int GM = 2;
  localparam int SL = 16;
  localparam int NN = 8;
  localparam int P  = 250 * TD;
  localparam int G  = GM * TD;
  localparam int L  = 1 + P + G;

  int hp_tab [NN] = '{47750, 42564, 37920, 35792, 31887, 28408, 25309, 23888};

  logic       clk_50MHz;
  logic       reset_button;
  logic       start;
  logic       stop;
  logic       buzzer_out;
  logic       busy;
  logic       done;
  logic [3:0] note_idx;

  logic        tg_en;
  logic [17:0] tg_hp;
  logic        tg_out;

  int errors = 0;
  int checks = 0;

  bit m_active;
  int m_k;
  int m_last_idx;

  melody_sequencer #(
    .TICK_DIV (TD),
    .GAP_MS   (GM),
    .SONG_LEN (SL)
  ) dut (
    .clk_50MHz    (clk_50MHz),
    .reset_button (reset_button),
    .start        (start),
    .stop         (stop),
    .buzzer_out   (buzzer_out),
    .busy         (busy),
    .done         (done),
    .note_idx     (note_idx)
  );

  tone_gen tg (
    .clk         (clk_50MHz),
    .reset       (reset_button),
    .enable      (tg_en),
    .half_period (tg_hp),
    .tone_out    (tg_out)
  );

  initial clk_50MHz = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {busy, done, buzzer, note_idx} k cycles after start was accepted.
  function automatic logic [6:0] timeline(input int k);
    int kk, i, r, p, hp;
    logic dn, buz;
`ifdef MELODY_LOOP_EN
    kk = k % (NN * L + 1);
    dn = (kk == 0) && (k > 0);
`else
    kk = k;
    dn = (k == NN * L + 1);
`endif
    if (kk < NN * L) begin
      i   = kk / L;
      r   = kk % L;
      buz = 1'b0;
      if (r >= 1 && r <= P) begin
        p   = r - 1;
        hp  = hp_tab[i];
        buz = (hp != 0) && (((p / (hp + 1)) % 2) == 1);
      end
      return {1'b1, dn, buz, 4'(i)};
    end
    return {1'b1, dn, 1'b0, 4'd8};
  endfunction

  // One clock of stimulus, model update and output comparison.
  task automatic step(input bit st, input bit sp);
    logic [6:0] exp;
    @(negedge clk_50MHz);
    start = st;
    stop  = sp;
    @(posedge clk_50MHz);
    #1;
    if (!m_active) begin
      if (st && !sp) begin
        m_active = 1'b1;
        m_k      = 0;
        $display("txn start accepted at %0t", $time);
      end
    end else if (sp) begin
      m_active = 1'b0;
      $display("txn stop at note %0d, %0t", m_last_idx, $time);
    end else begin
      m_k++;
`ifndef MELODY_LOOP_EN
      if (m_k >= NN * L + 2) begin
        m_active = 1'b0;
        $display("txn song finished at %0t", $time);
      end
`endif
    end
    exp = m_active ? timeline(m_k) : {3'b000, 4'(m_last_idx)};
    if (m_active) m_last_idx = int'(exp[3:0]);
    check("outputs", {25'd0, busy, done, buzzer_out, note_idx}, {25'd0, exp});
  endtask

  // Enable the tone generator for 'on' cycles, then hold it off for 'off'.
  task automatic tone_window(input int hp, input int on, input int off, output int rises);
    int n;
    logic prev, exp;
    n     = 0;
    prev  = 1'b0;
    rises = 0;
    for (int c = 0; c < on + off; c++) begin
      @(negedge clk_50MHz);
      tg_hp = 18'(hp);
      tg_en = (c < on);
      @(posedge clk_50MHz);
      #1;
      if (c < on) begin
        n++;
        exp = ((n / (hp + 1)) % 2) == 1;
      end else begin
        n   = 0;
        exp = 1'b0;
      end
      check("tone", {31'd0, tg_out}, {31'd0, exp});
      if (tg_out && !prev) rises++;
      prev = tg_out;
    end
    $display("txn tone hp=%0d on=%0d off=%0d rises=%0d", hp, on, off, rises);
  endtask

  initial begin
    int rises, target, guard;
    reset_button = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    tg_en        = 1'b0;
    tg_hp        = '0;
    m_active     = 1'b0;
    m_k          = 0;
    m_last_idx   = 0;
    repeat (3) @(posedge clk_50MHz);
    #1;
    check("reset_outputs", {25'd0, busy, done, buzzer_out, note_idx}, 32'd0);
    check("reset_tone", {31'd0, tg_out}, 32'd0);
    @(negedge clk_50MHz);
    reset_button = 1'b0;

    // Tone edges: half period 4 for 3 ms at 10 cycles/ms, then 20 quiet cycles.
    tone_window(4, 3 * TD, 20, rises);
    check("tone_periods", 32'(rises), 32'd3);
    for (int w = 0; w < 12; w++)
      tone_window(int'($urandom_range(0, 12)), int'($urandom_range(1, 60)),
                  int'($urandom_range(1, 8)), rises);

    // Full playback; extra start requests while busy must be ignored.
    step(1'b1, 1'b0);
    for (int c = 0; c < NN * L + 20; c++)
      step((c < NN * L - 100) && ($urandom_range(0, 15) == 0), 1'b0);

    // Abort in the middle of note 3, then start+stop together, then replay.
    step(1'b1, 1'b0);
    target = 3 * L + 1 + int'($urandom_range(0, P - 1));
    guard  = 0;
    while (m_active && m_k < target && guard < 4 * L) begin
      step($urandom_range(0, 31) == 0, 1'b0);
      guard++;
    end
    check("reached_note3", 32'(m_last_idx), 32'd3);
    step(1'b0, 1'b1);
    check("stop_busy", {31'd0, busy}, 32'd0);
    repeat (3) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    for (int c = 0; c < 2 * L; c++) step(1'b0, 1'b0);

    // Asynchronous reset in the middle of a note.
    @(posedge clk_50MHz);
    #3;
    reset_button = 1'b1;
    #1;
    check("async_reset", {25'd0, busy, done, buzzer_out, note_idx}, 32'd0);
    m_active   = 1'b0;
    m_last_idx = 0;
    repeat (2) @(negedge clk_50MHz);
    reset_button = 1'b0;
    repeat (5) step(1'b0, 1'b0);

    // Random start/stop traffic.
    for (int c = 0; c < 15000; c++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 2999) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
